// File: rtl/aemb2_mdu.sv
// ----------------------------------------------------------------------------
// aemb2_mdu -- multi-cycle multiply/divide unit for the AEMB2 execute stage.
//
// Multiplies go through a MUL_LAT-deep multiplier pipeline; divides use a
// radix-2 restoring divider that produces one quotient bit per enabled cycle.
// One operation is in flight at a time; a thread tag travels with it so the
// result can be steered back to the issuing hardware thread.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   ena_i    pipeline enable; 0 freezes every register
//   stb_i    issue request (ignored while busy_o)
//   opc_i    0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 IDIV, 5 IDIVU, 6/7 reserved
//   opa_i    rA: multiplicand / divisor
//   opb_i    rB: multiplier / dividend
//   tag_i    thread tag of the issued operation
//   abort_i  kill the in-flight operation (also discards a same-cycle issue)
//   busy_o   operation in flight
//   ack_o    result valid (one enabled-cycle pulse)
//   res_o    result, held until the next ack
//   tag_o    tag of the acked operation
//   dz_o     divide-by-zero, valid with ack_o, cleared on next acceptance
// ----------------------------------------------------------------------------
module aemb2_mdu #(
  parameter int DW      = 32,
  parameter int MUL_LAT = 2,
  parameter int DIV     = 1,
  parameter int TW      = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          ena_i,
  input  logic          stb_i,
  input  logic [2:0]    opc_i,
  input  logic [DW-1:0] opa_i,
  input  logic [DW-1:0] opb_i,
  input  logic [TW-1:0] tag_i,
  input  logic          abort_i,
  output logic          busy_o,
  output logic          ack_o,
  output logic [DW-1:0] res_o,
  output logic [TW-1:0] tag_o,
  output logic          dz_o
);

  localparam int CW = $clog2(DW) + 1;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_IDIV   = 3'd4;
  localparam logic [2:0] OP_IDIVU  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DSET = 3'd2,
    S_DIT  = 3'd3,
    S_DFIX = 3'd4,
    S_ACK  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    opc_q, opc_d;
  logic [DW-1:0] opa_q, opa_d;     // multiplicand, later |divisor|
  logic [DW-1:0] opb_q, opb_d;     // multiplier, later dividend/quotient shifter
  logic [DW-1:0] rem_q, rem_d;     // partial remainder
  logic          neg_q, neg_d;     // negate quotient in DFIX
  logic          zero_q, zero_d;   // force a zero result in DFIX
  logic          dzf_q, dzf_d;     // pending divide-by-zero
  logic [TW-1:0] tagin_q, tagin_d;
  logic [DW-1:0] res_q, res_d;
  logic [TW-1:0] tag_q, tag_d;
  logic          dz_q, dz_d;

  // --------------------------------------------------------------------------
  // Multiplier. Operands are sign- or zero-extended to 2*DW; the low 2*DW
  // bits of the product are correct for every signedness combination.
  // --------------------------------------------------------------------------
  logic            sgn_a, sgn_b;
  logic [2*DW-1:0] mul_a, mul_b, prod_c, mul_res;

  assign sgn_a  = (opc_q == OP_MULH) || (opc_q == OP_MULHSU);
  assign sgn_b  = (opc_q == OP_MULH);
  assign mul_a  = {{DW{sgn_a & opa_q[DW-1]}}, opa_q};
  assign mul_b  = {{DW{sgn_b & opb_q[DW-1]}}, opb_q};
  assign prod_c = mul_a * mul_b;

  // MUL_LAT-1 product registers; the last edge of the latency loads res_q.
  if (MUL_LAT == 1) begin : g_nopipe
    assign mul_res = prod_c;
  end else begin : g_pipe
    logic [2*DW-1:0] pipe_q [MUL_LAT-1];
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < MUL_LAT - 1; i++) pipe_q[i] <= '0;
      end else if (ena_i) begin
        pipe_q[0] <= prod_c;
        for (int i = 1; i < MUL_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign mul_res = pipe_q[MUL_LAT-2];
  end

  // --------------------------------------------------------------------------
  // Restoring divider step: shift the dividend MSB into the remainder and
  // subtract the divisor; a non-negative difference yields a quotient 1.
  // --------------------------------------------------------------------------
  logic [DW:0] div_shift, div_diff;

  assign div_shift = {rem_q, opb_q[DW-1]};
  assign div_diff  = div_shift - {1'b0, opa_q};

  logic accept;
  assign accept = stb_i & ~abort_i & ((state_q == S_IDLE) || (state_q == S_ACK));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opc_d   = opc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    rem_d   = rem_q;
    neg_d   = neg_q;
    zero_d  = zero_q;
    dzf_d   = dzf_q;
    tagin_d = tagin_q;
    res_d   = res_q;
    tag_d   = tag_q;
    dz_d    = dz_q;

    case (state_q)
      S_IDLE, S_ACK: begin
        state_d = S_IDLE;
        if (accept) begin
          opc_d   = opc_i;
          opa_d   = opa_i;
          opb_d   = opb_i;
          tagin_d = tag_i;
          rem_d   = '0;
          neg_d   = 1'b0;
          zero_d  = 1'b0;
          dzf_d   = 1'b0;
          dz_d    = 1'b0;
          cnt_d   = CW'(MUL_LAT - 1);
          if (opc_i <= 3'd3) begin
            state_d = S_MUL;
          end else if ((opc_i == OP_IDIV || opc_i == OP_IDIVU) && (DIV != 0)) begin
            state_d = S_DSET;
          end else begin
            // Reserved opcodes and divides without a divider: zero after 1 edge.
            state_d = S_DFIX;
            zero_d  = 1'b1;
          end
        end
      end

      S_MUL: begin
        if (cnt_q == '0) begin
          state_d = S_ACK;
          res_d   = (opc_q == OP_MUL) ? mul_res[DW-1:0] : mul_res[2*DW-1:DW];
          tag_d   = tagin_q;
          dz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      S_DSET: begin
        if (opa_q == '0) begin
          // Divide-by-zero passes through DFIX so it acks two edges after issue.
          state_d = S_DFIX;
          zero_d  = 1'b1;
          dzf_d   = 1'b1;
        end else begin
          if (opc_q == OP_IDIV) begin
            neg_d = opa_q[DW-1] ^ opb_q[DW-1];
            if (opa_q[DW-1]) opa_d = '0 - opa_q;
            if (opb_q[DW-1]) opb_d = '0 - opb_q;
          end
          rem_d   = '0;
          cnt_d   = CW'(DW);
          state_d = S_DIT;
        end
      end

      S_DIT: begin
        if (!div_diff[DW]) begin
          rem_d = div_diff[DW-1:0];
          opb_d = {opb_q[DW-2:0], 1'b1};
        end else begin
          rem_d = div_shift[DW-1:0];
          opb_d = {opb_q[DW-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DFIX;
      end

      S_DFIX: begin
        state_d = S_ACK;
        if (zero_q)     res_d = '0;
        else if (neg_q) res_d = '0 - opb_q;
        else            res_d = opb_q;
        dz_d  = dzf_q;
        tag_d = tagin_q;
      end

      default: state_d = S_IDLE;
    endcase

    // Abort wins over everything: no ack, visible outputs untouched.
    if (abort_i) begin
      state_d = S_IDLE;
      res_d   = res_q;
      tag_d   = tag_q;
      dz_d    = dz_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opc_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b0;
      dzf_q   <= 1'b0;
      tagin_q <= '0;
      res_q   <= '0;
      tag_q   <= '0;
      dz_q    <= 1'b0;
    end else if (ena_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opc_q   <= opc_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rem_q   <= rem_d;
      neg_q   <= neg_d;
      zero_q  <= zero_d;
      dzf_q   <= dzf_d;
      tagin_q <= tagin_d;
      res_q   <= res_d;
      tag_q   <= tag_d;
      dz_q    <= dz_d;
    end
  end

  assign busy_o = (state_q == S_MUL) || (state_q == S_DSET) ||
                  (state_q == S_DIT) || (state_q == S_DFIX);
  assign ack_o  = (state_q == S_ACK);
  assign res_o  = res_q;
  assign tag_o  = tag_q;
  assign dz_o   = dz_q;

endmodule

// File: tb/tb_aemb2_mdu.sv
// ----------------------------------------------------------------------------
// Self-checking bench for aemb2_mdu (DW=32, MUL_LAT=2, DIV=1, TW=1).
// Directed cases plus randomized operations checked against a plain
// arithmetic reference model.
// ----------------------------------------------------------------------------
module tb_aemb2_mdu;
  localparam int DW = 32;
  localparam int MUL_LAT = 2;
  localparam int DIV = 1;
  localparam int TW = 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          ena_i = 1'b1;
  logic          stb_i = 1'b0;
  logic [2:0]    opc_i = '0;
  logic [DW-1:0] opa_i = '0;
  logic [DW-1:0] opb_i = '0;
  logic [TW-1:0] tag_i = '0;
  logic          abort_i = 1'b0;
  logic          busy_o, ack_o, dz_o;
  logic [DW-1:0] res_o;
  logic [TW-1:0] tag_o;

  int n_checks = 0;
  int n_fail   = 0;

  aemb2_mdu #(.DW(DW), .MUL_LAT(MUL_LAT), .DIV(DIV), .TW(TW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ena_i(ena_i), .stb_i(stb_i),
    .opc_i(opc_i), .opa_i(opa_i), .opb_i(opb_i), .tag_i(tag_i),
    .abort_i(abort_i), .busy_o(busy_o), .ack_o(ack_o), .res_o(res_o),
    .tag_o(tag_o), .dz_o(dz_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: returns {dz, result}.
  function automatic logic [32:0] ref_op(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      qs;
    logic [31:0] q;
    logic        dz;
    dz = 1'b0;
    q  = '0;
    case (opc)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; q = p[31:0]; end
      3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; q = p[63:32]; end
      3'd2: begin p = {{32{a[31]}}, a} * {32'b0, b}; q = p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; q = p[63:32]; end
      3'd4: begin
        if (a == 0) dz = 1'b1;
        else begin
          qs = longint'($signed(b)) / longint'($signed(a));
          q  = qs[31:0];
        end
      end
      3'd5: begin
        if (a == 0) dz = 1'b1;
        else q = b / a;
      end
      default: q = '0;
    endcase
    return {dz, q};
  endfunction

  function automatic int ref_lat(input logic [2:0] opc, input logic [31:0] a);
    if (opc <= 3'd3) return MUL_LAT;
    if (opc == 3'd4 || opc == 3'd5) return (a == 0) ? 2 : DW + 2;
    return 1;
  endfunction

  // Drive one request for a single edge; inputs are scrambled afterwards so a
  // design that fails to capture them shows up.
  task automatic issue(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b, input logic tg);
    stb_i = 1'b1; opc_i = opc; opa_i = a; opb_i = b; tag_i = tg;
    tick();
    stb_i = 1'b0;
    opc_i = 3'($urandom_range(0, 7));
    opa_i = $urandom;
    opb_i = $urandom;
    tag_i = ~tg;
  endtask

  task automatic wait_ack(output int n);
    n = 0;
    while (ack_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] opc, input logic [31:0] a,
                        input logic [31:0] b, input logic tg, input logic [31:0] exp_res,
                        input logic exp_dz, input int exp_lat);
    int n;
    issue(opc, a, b, tg);
    check({name, ".busy"}, busy_o, 1);
    wait_ack(n);
    check({name, ".lat"}, n, exp_lat);
    check({name, ".res"}, res_o, exp_res);
    check({name, ".dz"}, dz_o, exp_dz);
    check({name, ".tag"}, tag_o, tg);
    $display("op %-10s opc=%0d a=%h b=%h -> res=%h dz=%0d tag=%0d lat=%0d",
             name, opc, a, b, res_o, dz_o, tag_o, n);
  endtask

  initial begin
    int n, n2, seen;
    logic [32:0] exp;
    logic [2:0]  ropc;
    logic [31:0] ra, rb;
    logic        rt;

    // Reset
    repeat (2) @(posedge clk_i);
    #1;
    check("rst.busy", busy_o, 0);
    check("rst.ack", ack_o, 0);
    check("rst.res", res_o, 0);
    check("rst.tag", tag_o, 0);
    check("rst.dz", dz_o, 0);
    rst_ni = 1'b1;
    tick();

    // Directed cases with hand-derived expectations
    run_op("mul",    3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000001, 1'b0, 2);
    run_op("mulhu",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFE, 1'b0, 2);
    run_op("mulh",   3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, 2);
    run_op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'h00000002, 1'b0, 32'hFFFFFFFF, 1'b0, 2);
    run_op("idiv",   3'd4, 32'h00000002, 32'hFFFFFFF9, 1'b0, 32'hFFFFFFFD, 1'b0, 34);
    run_op("idivu",  3'd5, 32'h00000002, 32'hFFFFFFF9, 1'b1, 32'h7FFFFFFC, 1'b0, 34);
    run_op("idiv0",  3'd4, 32'h00000000, 32'h12345678, 1'b1, 32'h00000000, 1'b1, 2);
    // dz clears on the next acceptance
    issue(3'd0, 32'd2, 32'd3, 1'b0);
    check("dz.clear", dz_o, 0);
    wait_ack(n);
    check("dzclr.res", res_o, 6);
    run_op("idivovf", 3'd4, 32'hFFFFFFFF, 32'h80000000, 1'b0, 32'h80000000, 1'b0, 34);
    run_op("rsv6",    3'd6, 32'h11111111, 32'h22222222, 1'b1, 32'h00000000, 1'b0, 1);
    tick();
    check("ack.pulse", ack_o, 0);

    // Enable low for 5 cycles mid-divide, then one cycle during ACK
    issue(3'd4, 32'd2, 32'hFFFFFFF9, 1'b1);
    repeat (9) tick();
    ena_i = 1'b0;
    repeat (5) tick();
    check("ena.busy", busy_o, 1);
    ena_i = 1'b1;
    wait_ack(n);
    check("ena.lat", 9 + 5 + n, 39);
    check("ena.res", res_o, 32'hFFFFFFFD);
    ena_i = 1'b0;
    tick();
    check("ena.ackhold", ack_o, 1);
    ena_i = 1'b1;
    tick();
    check("ena.ackdrop", ack_o, 0);
    $display("op ena-stall  lat=%0d res=%h", 14 + n, res_o);

    // Abort at iteration 10 of a divide
    issue(3'd5, 32'd3, 32'd1000, 1'b1);
    repeat (11) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort.busy", busy_o, 0);
    check("abort.ack", ack_o, 0);
    seen = 0;
    repeat (40) begin tick(); if (ack_o) seen = 1; end
    check("abort.noack", seen, 0);
    $display("op abort     ack_seen=%0d", seen);
    run_op("mul3x5", 3'd0, 32'd3, 32'd5, 1'b0, 32'd15, 1'b0, 2);

    // Abort together with issue: discarded
    stb_i = 1'b1; abort_i = 1'b1; opc_i = 3'd0; opa_i = 32'd7; opb_i = 32'd7;
    tick();
    stb_i = 1'b0; abort_i = 1'b0;
    check("abortstb.busy", busy_o, 0);
    seen = 0;
    repeat (5) begin tick(); if (ack_o) seen = 1; end
    check("abortstb.noack", seen, 0);
    check("abortstb.res", res_o, 15);

    // Back-to-back issue during ACK
    issue(3'd0, 32'd7, 32'd9, 1'b1);
    wait_ack(n);
    check("b2b.lat1", n, 2);
    check("b2b.res1", res_o, 63);
    issue(3'd3, 32'h80000000, 32'd4, 1'b0);
    check("b2b.ackdrop", ack_o, 0);
    check("b2b.busy", busy_o, 1);
    wait_ack(n2);
    check("b2b.edge2", 2 + 1 + n2, 5);
    check("b2b.res2", res_o, 2);
    check("b2b.tag2", tag_o, 0);
    $display("op b2b       res=%h edge=%0d", res_o, 3 + n2);

    // Issue while busy is dropped
    issue(3'd4, 32'd5, 32'd100, 1'b1);
    repeat (4) tick();
    stb_i = 1'b1; opc_i = 3'd0; opa_i = 32'd2; opb_i = 32'd2; tag_i = 1'b0;
    tick();
    stb_i = 1'b0;
    wait_ack(n);
    check("busyiss.lat", 5 + n, 34);
    check("busyiss.res", res_o, 20);
    check("busyiss.tag", tag_o, 1);
    seen = 0;
    repeat (10) begin tick(); if (ack_o) seen = 1; end
    check("busyiss.noextra", seen, 0);
    $display("op busy-drop res=%h extra_ack=%0d", res_o, seen);

    // Randomized operations against the reference model
    for (int i = 0; i < 60; i++) begin
      ropc = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'h0;
        1: ra = 32'hFFFFFFFF;
        2: rb = 32'h80000000;
        3: ra = 32'($urandom_range(1, 20));
        default: ;
      endcase
      rt = 1'($urandom);
      exp = ref_op(ropc, ra, rb);
      run_op($sformatf("rnd%0d", i), ropc, ra, rb, rt, exp[31:0], exp[32], ref_lat(ropc, ra));
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Async reset mid-multiply
    issue(3'd0, 32'd11, 32'd13, 1'b1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst.res", res_o, 0);
    check("arst.tag", tag_o, 0);
    check("arst.busy", busy_o, 0);
    check("arst.ack", ack_o, 0);
    check("arst.dz", dz_o, 0);
    #1;
    rst_ni = 1'b1;
    seen = 0;
    repeat (5) begin tick(); if (ack_o) seen = 1; end
    check("arst.noack", seen, 0);
    $display("op async-rst res=%h ack_seen=%0d", res_o, seen);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1);
  end

endmodule
